lcd_cmd_arbiter: RTL and testbench



---
 rtl/lcd_cmd_arbiter.sv | 227 ++++++++++++++++++++++
 tb/tb_lcd_cmd_arbiter.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_cmd_arbiter.sv
// Round-robin, burst-locking arbiter that feeds two command requesters into one LCD controller.
// Optional watchdogs (ISSUE timeout + stale-lock release) are built when LCD_ARB_TIMEOUT_EN is defined.
module lcd_cmd_arbiter #(
  parameter int GAP     = 160,
  parameter int TIMEOUT = 1024
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       a_req,
  input  logic [9:0] a_cmd,
  input  logic       a_last,
  output logic       a_ack,
  input  logic       b_req,
  input  logic [9:0] b_cmd,
  input  logic       b_last,
  output logic       b_ack,
  input  logic       busy,
  output logic       lcd_enable,
  output logic [9:0] lcd_bus,
  output logic [1:0] grant,
  output logic       err
);

  localparam int GW = $clog2(GAP + 1);

  // Parameter sanity: the guard must outlast the controller's execute window.
  if (GAP < 152) begin : g_bad_gap
    $error("lcd_cmd_arbiter: GAP must be at least 152");
  end
  if (TIMEOUT < 2) begin : g_bad_timeout
    $error("lcd_cmd_arbiter: TIMEOUT must be at least 2");
  end

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_GUARD = 2'd2
  } state_t;

  state_t          r_state,   w_state_nxt;
  logic [GW-1:0]   r_guard,   w_guard_nxt;
  logic            r_enable,  w_enable_nxt;
  logic [9:0]      r_bus,     w_bus_nxt;
  logic            r_a_ack,   w_a_ack_nxt;
  logic            r_b_ack,   w_b_ack_nxt;
  logic [1:0]      r_grant,   w_grant_nxt;
  logic            r_lock_vld, w_lock_vld_nxt;
  logic            r_lock_b,  w_lock_b_nxt;
  logic            r_prio_b,  w_prio_b_nxt;

  logic            w_eligible;
  logic            w_pick_a;
  logic            w_pick_b;

`ifdef LCD_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);

  logic            r_err,       w_err_nxt;
  logic [TW-1:0]   r_wdog,      w_wdog_nxt;
  logic [TW-1:0]   r_lock_wdog, w_lock_wdog_nxt;
  logic            w_owner_req;

  assign w_owner_req = r_lock_b ? b_req : a_req;
`endif

  // Requests are only looked at in IDLE, with the controller free and the guard expired.
  assign w_eligible = (r_state == S_IDLE) && !busy && (r_guard == '0);

  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    w_pick_a = 1'b0;
    w_pick_b = 1'b0;
    if (w_eligible) begin
      if (r_lock_vld) begin
        w_pick_a = !r_lock_b && a_req;
        w_pick_b =  r_lock_b && b_req;
      end else if (a_req && b_req) begin
        w_pick_a = !r_prio_b;
        w_pick_b =  r_prio_b;
      end else begin
        w_pick_a = a_req;
        w_pick_b = b_req;
      end
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_guard_nxt    = r_guard;
    w_enable_nxt   = r_enable;
    w_bus_nxt      = r_bus;
    w_a_ack_nxt    = 1'b0;
    w_b_ack_nxt    = 1'b0;
    w_grant_nxt    = r_grant;
    w_lock_vld_nxt = r_lock_vld;
    w_lock_b_nxt   = r_lock_b;
    w_prio_b_nxt   = r_prio_b;
`ifdef LCD_ARB_TIMEOUT_EN
    w_err_nxt       = r_err;
    w_wdog_nxt      = r_wdog;
    w_lock_wdog_nxt = '0;
`endif

    unique case (r_state)
      S_IDLE: begin
        if (w_pick_a) begin
          w_bus_nxt      = a_cmd;
          w_enable_nxt   = 1'b1;
          w_a_ack_nxt    = 1'b1;
          w_grant_nxt    = 2'b01;
          w_lock_vld_nxt = !a_last;
          w_lock_b_nxt   = 1'b0;
          w_prio_b_nxt   = 1'b1;
          w_state_nxt    = S_ISSUE;
`ifdef LCD_ARB_TIMEOUT_EN
          w_wdog_nxt     = '0;
`endif
        end else if (w_pick_b) begin
          w_bus_nxt      = b_cmd;
          w_enable_nxt   = 1'b1;
          w_b_ack_nxt    = 1'b1;
          w_grant_nxt    = 2'b10;
          w_lock_vld_nxt = !b_last;
          w_lock_b_nxt   = 1'b1;
          w_prio_b_nxt   = 1'b0;
          w_state_nxt    = S_ISSUE;
`ifdef LCD_ARB_TIMEOUT_EN
          w_wdog_nxt     = '0;
`endif
        end
`ifdef LCD_ARB_TIMEOUT_EN
        // Release a lock whose owner has gone quiet mid-burst.
        else if (r_lock_vld && !w_owner_req) begin
          if (r_lock_wdog == TW'(TIMEOUT - 1)) begin
            w_lock_vld_nxt = 1'b0;
          end else begin
            w_lock_wdog_nxt = r_lock_wdog + TW'(1);
          end
        end
`endif
      end

      S_ISSUE: begin
        if (busy) begin
          w_enable_nxt = 1'b0;
          w_guard_nxt  = GW'(GAP);
          w_state_nxt  = S_GUARD;
        end
`ifdef LCD_ARB_TIMEOUT_EN
        else if (r_wdog == TW'(TIMEOUT - 1)) begin
          w_enable_nxt   = 1'b0;
          w_err_nxt      = 1'b1;
          w_lock_vld_nxt = 1'b0;
          w_guard_nxt    = GW'(GAP);
          w_state_nxt    = S_GUARD;
        end else begin
          w_wdog_nxt = r_wdog + TW'(1);
        end
`endif
      end

      S_GUARD: begin
        if (r_guard != '0) begin
          w_guard_nxt = r_guard - GW'(1);
        end
        // Leave on the cycle the count lands on 0 so the spacing is GAP+3.
        if ((r_guard <= GW'(1)) && !busy) begin
          w_state_nxt = S_IDLE;
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_guard    <= '0;
      r_enable   <= 1'b0;
      r_bus      <= '0;
      r_a_ack    <= 1'b0;
      r_b_ack    <= 1'b0;
      r_grant    <= 2'b00;
      r_lock_vld <= 1'b0;
      r_lock_b   <= 1'b0;
      r_prio_b   <= 1'b0;
`ifdef LCD_ARB_TIMEOUT_EN
      r_err       <= 1'b0;
      r_wdog      <= '0;
      r_lock_wdog <= '0;
`endif
    end else begin
      // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
      r_state    <= w_state_nxt;
      r_guard    <= w_guard_nxt;
      r_enable   <= w_enable_nxt;
      r_bus      <= w_bus_nxt;
      r_a_ack    <= w_a_ack_nxt;
      r_b_ack    <= w_b_ack_nxt;
      r_grant    <= w_grant_nxt;
      r_lock_vld <= w_lock_vld_nxt;
      r_lock_b   <= w_lock_b_nxt;
      r_prio_b   <= w_prio_b_nxt;
`ifdef LCD_ARB_TIMEOUT_EN
      r_err       <= w_err_nxt;
      r_wdog      <= w_wdog_nxt;
      r_lock_wdog <= w_lock_wdog_nxt;
`endif
    end
  end

  assign a_ack      = r_a_ack;
  assign b_ack      = r_b_ack;
  assign lcd_enable = r_enable;
  assign lcd_bus    = r_bus;
  assign grant      = r_grant;

`ifdef LCD_ARB_TIMEOUT_EN
  assign err = r_err;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_lcd_cmd_arbiter.sv
// Directed bench for lcd_cmd_arbiter with a small LCD controller busy model.
// Expectations follow the LCD_ARB_TIMEOUT_EN setting of the build.
module tb_lcd_cmd_arbiter;

  localparam int GAP = 160;
`ifdef LCD_ARB_TIMEOUT_EN
  localparam int TB_TIMEOUT = 16;
`else
  localparam int TB_TIMEOUT = 1024;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       a_req = 1'b0, b_req = 1'b0;
  logic [9:0] a_cmd = '0, b_cmd = '0;
  logic       a_last = 1'b0, b_last = 1'b0;
  logic       a_ack, b_ack;
  logic       busy = 1'b1;
  logic       lcd_enable;
  logic [9:0] lcd_bus;
  logic [1:0] grant;
  logic       err;

  int vectors = 0;
  int miscompares = 0;

  // Controller model: 0 = held busy (init), 1 = one-cycle busy pulse on capture, 2 = never busy.
  int mode = 0;

  lcd_cmd_arbiter #(.GAP(GAP), .TIMEOUT(TB_TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .a_req(a_req), .a_cmd(a_cmd), .a_last(a_last), .a_ack(a_ack),
    .b_req(b_req), .b_cmd(b_cmd), .b_last(b_last), .b_ack(b_ack),
    .busy(busy), .lcd_enable(lcd_enable), .lcd_bus(lcd_bus),
    .grant(grant), .err(err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    case (mode)
      0: busy <= 1'b1;
      1: begin
        if (rst)             busy <= 1'b0;
        else if (busy)       busy <= 1'b0;
        else if (lcd_enable) busy <= 1'b1;
      end
      default: busy <= 1'b0;
    endcase
  end

  // Requester word queues and issue log.
  logic [9:0] a_cmds[$], b_cmds[$];
  logic       a_lasts[$], b_lasts[$];
  int         iss_who[8];
  int         iss_cyc[8];
  logic [9:0] iss_bus[8];
  logic [1:0] iss_grant[8];
  int         n_issues;

  task automatic load_a();
    if (a_cmds.size() > 0) begin
      a_req = 1'b1; a_cmd = a_cmds[0]; a_last = a_lasts[0];
    end else a_req = 1'b0;
  endtask

  task automatic load_b();
    if (b_cmds.size() > 0) begin
      b_req = 1'b1; b_cmd = b_cmds[0]; b_last = b_lasts[0];
    end else b_req = 1'b0;
  endtask

  task automatic clear_reqs();
    a_cmds.delete(); a_lasts.delete(); b_cmds.delete(); b_lasts.delete();
    a_req = 1'b0; b_req = 1'b0;
  endtask

  task automatic push_a(input logic [9:0] c, input logic l);
    a_cmds.push_back(c); a_lasts.push_back(l);
  endtask

  task automatic push_b(input logic [9:0] c, input logic l);
    b_cmds.push_back(c); b_lasts.push_back(l);
  endtask

  task automatic do_reset(input int edges);
    @(negedge clk);
    rst = 1'b1;
    repeat (edges) @(negedge clk);
    rst = 1'b0;
  endtask

  // Watches acks for up to 'budget' cycles, logging issues and advancing the requesters.
  task automatic run_issues(input int n, input int budget);
    int cyc;
    cyc = 0;
    n_issues = 0;
    for (int i = 0; i < 8; i++) begin
      iss_who[i] = -1; iss_cyc[i] = -1; iss_bus[i] = 'x; iss_grant[i] = 'x;
    end
    while (n_issues < n && cyc < budget) begin
      @(negedge clk);
      cyc++;
      if ((a_ack || b_ack) && n_issues < 8) begin
        iss_who[n_issues]   = (a_ack && b_ack) ? 2 : (a_ack ? 0 : 1);
        iss_cyc[n_issues]   = cyc;
        iss_bus[n_issues]   = lcd_bus;
        iss_grant[n_issues] = grant;
        n_issues++;
        if (a_ack) begin void'(a_cmds.pop_front()); void'(a_lasts.pop_front()); load_a(); end
        if (b_ack) begin void'(b_cmds.pop_front()); void'(b_lasts.pop_front()); load_b(); end
      end
    end
  endtask

  task automatic test_reset();
    int bad;
    mode = 0;
    clear_reqs();
    a_req = 1'b1; a_cmd = 10'h241; a_last = 1'b1;
    do_reset(2);
    vectors++; if (lcd_enable !== 1'b0) begin miscompares++; $display("FAIL reset_enable: got %b want 0", lcd_enable); end
    vectors++; if (lcd_bus !== 10'h000) begin miscompares++; $display("FAIL reset_bus: got %h want 000", lcd_bus); end
    vectors++; if (grant !== 2'b00) begin miscompares++; $display("FAIL reset_grant: got %b want 00", grant); end
    vectors++; if ({a_ack, b_ack} !== 2'b00) begin miscompares++; $display("FAIL reset_acks: got %b want 00", {a_ack, b_ack}); end
    vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL reset_err: got %b want 0", err); end
    bad = 0;
    repeat (4500) begin
      @(negedge clk);
      if (a_ack || b_ack || lcd_enable) bad++;
    end
    vectors++; if (bad !== 0) begin miscompares++; $display("FAIL init_busy_quiet: got %0d active cycles want 0", bad); end
    mode = 1;
    @(negedge clk);
    vectors++; if ({a_ack, lcd_enable} !== 2'b00) begin miscompares++; $display("FAIL busy_fall_edge: got ack/en %b want 00", {a_ack, lcd_enable}); end
    @(negedge clk);
    vectors++; if ({a_ack, lcd_enable} !== 2'b11) begin miscompares++; $display("FAIL first_issue: got ack/en %b want 11", {a_ack, lcd_enable}); end
    vectors++; if (lcd_bus !== 10'h241) begin miscompares++; $display("FAIL first_bus: got %h want 241", lcd_bus); end
    vectors++; if (grant !== 2'b01) begin miscompares++; $display("FAIL first_grant: got %b want 01", grant); end
    a_req = 1'b0;
    @(negedge clk);
    vectors++; if (a_ack !== 1'b0) begin miscompares++; $display("FAIL ack_one_cycle: got %b want 0", a_ack); end
    repeat (3) @(negedge clk);
    vectors++; if (lcd_enable !== 1'b0) begin miscompares++; $display("FAIL enable_drop: got %b want 0", lcd_enable); end
    vectors++; if (lcd_bus !== 10'h241) begin miscompares++; $display("FAIL bus_hold: got %h want 241", lcd_bus); end
  endtask

  task automatic test_round_robin();
    int         exp_who[4];
    logic [9:0] exp_bus[4];
    exp_who = '{0, 1, 0, 1};
    exp_bus = '{10'h101, 10'h202, 10'h103, 10'h204};
    mode = 1;
    clear_reqs();
    push_a(10'h101, 1'b1); push_a(10'h103, 1'b1);
    push_b(10'h202, 1'b1); push_b(10'h204, 1'b1);
    load_a(); load_b();
    do_reset(2);
    run_issues(4, 800);
    vectors++; if (n_issues !== 4) begin miscompares++; $display("FAIL rr_count: got %0d want 4", n_issues); end
    vectors++; if (iss_cyc[0] !== 1) begin miscompares++; $display("FAIL rr_latency: got %0d want 1", iss_cyc[0]); end
    for (int i = 0; i < 4; i++) begin
      vectors++; if (iss_who[i] !== exp_who[i]) begin miscompares++; $display("FAIL rr_who[%0d]: got %0d want %0d", i, iss_who[i], exp_who[i]); end
      vectors++; if (iss_bus[i] !== exp_bus[i]) begin miscompares++; $display("FAIL rr_bus[%0d]: got %h want %h", i, iss_bus[i], exp_bus[i]); end
      if (i > 0) begin
        vectors++; if (iss_cyc[i] - iss_cyc[i-1] !== 163) begin miscompares++; $display("FAIL rr_spacing[%0d]: got %0d want 163", i, iss_cyc[i] - iss_cyc[i-1]); end
      end
    end
  endtask

  task automatic test_burst();
    int         exp_who[4];
    logic [9:0] exp_bus[4];
    logic [1:0] exp_grant[4];
    exp_who   = '{0, 0, 0, 1};
    exp_bus   = '{10'h248, 10'h245, 10'h24C, 10'h001};
    exp_grant = '{2'b01, 2'b01, 2'b01, 2'b10};
    mode = 1;
    clear_reqs();
    push_a(10'h248, 1'b0); push_a(10'h245, 1'b0); push_a(10'h24C, 1'b1);
    push_b(10'h001, 1'b1);
    load_a(); load_b();
    do_reset(2);
    run_issues(4, 800);
    vectors++; if (n_issues !== 4) begin miscompares++; $display("FAIL burst_count: got %0d want 4", n_issues); end
    for (int i = 0; i < 4; i++) begin
      vectors++; if (iss_who[i] !== exp_who[i]) begin miscompares++; $display("FAIL burst_who[%0d]: got %0d want %0d", i, iss_who[i], exp_who[i]); end
      vectors++; if (iss_bus[i] !== exp_bus[i]) begin miscompares++; $display("FAIL burst_bus[%0d]: got %h want %h", i, iss_bus[i], exp_bus[i]); end
      vectors++; if (iss_grant[i] !== exp_grant[i]) begin miscompares++; $display("FAIL burst_grant[%0d]: got %b want %b", i, iss_grant[i], exp_grant[i]); end
    end
  endtask

  task automatic test_lock_hold();
    mode = 1;
    clear_reqs();
    push_a(10'h030, 1'b0);
    push_b(10'h0B0, 1'b1);
    load_a(); load_b();
    do_reset(2);
    run_issues(2, 600);
    vectors++; if (iss_who[0] !== 0) begin miscompares++; $display("FAIL lock_first_who: got %0d want 0", iss_who[0]); end
`ifdef LCD_ARB_TIMEOUT_EN
    vectors++; if (n_issues !== 2) begin miscompares++; $display("FAIL lock_release_count: got %0d want 2", n_issues); end
    vectors++; if (iss_who[1] !== 1) begin miscompares++; $display("FAIL lock_release_who: got %0d want 1", iss_who[1]); end
    vectors++; if (iss_cyc[1] - iss_cyc[0] !== GAP + 3 + TB_TIMEOUT) begin miscompares++; $display("FAIL lock_release_spacing: got %0d want %0d", iss_cyc[1] - iss_cyc[0], GAP + 3 + TB_TIMEOUT); end
    vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL lock_release_err: got %b want 0", err); end
`else
    vectors++; if (n_issues !== 1) begin miscompares++; $display("FAIL lock_hold_count: got %0d want 1", n_issues); end
    vectors++; if (b_req !== 1'b1) begin miscompares++; $display("FAIL lock_hold_b_pending: got %b want 1", b_req); end
`endif
  endtask

  task automatic test_no_busy();
    int len;
    mode = 2;
    clear_reqs();
    push_a(10'h2AA, 1'b1);
    load_a();
    do_reset(2);
    run_issues(1, 50);
    vectors++; if (n_issues !== 1) begin miscompares++; $display("FAIL nobusy_issue: got %0d want 1", n_issues); end
    len = 0;
    for (int k = 0; k < 300; k++) begin
      if (!lcd_enable) break;
      len++;
      @(negedge clk);
    end
`ifdef LCD_ARB_TIMEOUT_EN
    vectors++; if (len !== TB_TIMEOUT) begin miscompares++; $display("FAIL timeout_len: got %0d want %0d", len, TB_TIMEOUT); end
    vectors++; if (err !== 1'b1) begin miscompares++; $display("FAIL timeout_err: got %b want 1", err); end
    a_req = 1'b1; a_cmd = 10'h2AB; a_last = 1'b1;
    len = 0;
    while (!a_ack && len < 400) begin
      @(negedge clk);
      len++;
    end
    a_req = 1'b0;
    vectors++; if (len !== GAP + 1) begin miscompares++; $display("FAIL timeout_next_issue: got %0d want %0d", len, GAP + 1); end
`else
    vectors++; if (len !== 300) begin miscompares++; $display("FAIL nobusy_enable_held: got %0d want 300", len); end
    vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL nobusy_err: got %b want 0", err); end
`endif
  endtask

  task automatic test_reset_mid_issue();
    int bad;
    mode = 2;
    clear_reqs();
    push_a(10'h2C3, 1'b1);
    load_a();
    do_reset(2);
    run_issues(1, 50);
    push_b(10'h0B5, 1'b1);
    load_b();
    repeat (3) @(negedge clk);
    vectors++; if (lcd_enable !== 1'b1) begin miscompares++; $display("FAIL midissue_in_issue: got %b want 1", lcd_enable); end
    mode = 0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    vectors++; if (lcd_enable !== 1'b0) begin miscompares++; $display("FAIL midissue_enable: got %b want 0", lcd_enable); end
    vectors++; if (grant !== 2'b00) begin miscompares++; $display("FAIL midissue_grant: got %b want 00", grant); end
    bad = 0;
    repeat (5) begin
      @(negedge clk);
      if (a_ack || b_ack || lcd_enable) bad++;
    end
    vectors++; if (bad !== 0) begin miscompares++; $display("FAIL midissue_wait_busy: got %0d active cycles want 0", bad); end
    mode = 1;
    run_issues(1, 10);
    vectors++; if (iss_who[0] !== 1) begin miscompares++; $display("FAIL midissue_who: got %0d want 1", iss_who[0]); end
    vectors++; if (iss_cyc[0] !== 2) begin miscompares++; $display("FAIL midissue_latency: got %0d want 2", iss_cyc[0]); end
    vectors++; if (iss_bus[0] !== 10'h0B5) begin miscompares++; $display("FAIL midissue_bus: got %h want 0b5", iss_bus[0]); end
    vectors++; if (iss_grant[0] !== 2'b10) begin miscompares++; $display("FAIL midissue_grant_b: got %b want 10", iss_grant[0]); end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_burst();
    test_lock_hold();
    test_no_busy();
    test_reset_mid_issue();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
